// File: rtl/rotor2_return.sv
// Return-path stage of Enigma rotor 2: maps reflector-side letters back through the
// rotor wiring, owns the rotor position/carry, optional one-hot output via ROTOR2_RETURN_ONEHOT_EN.
module rotor2_return (
    input  logic        clock,
    input  logic        resetn,
    input  logic        set,
    input  logic [4:0]  set_state,
    input  logic        step,
    input  logic        in_valid,
    input  logic [4:0]  in_letter,
    output logic        in_ready,
    output logic        out_valid,
    output logic [4:0]  out_letter,
    output logic        out_error,
    input  logic        out_ready,
    output logic [4:0]  state,
`ifdef ROTOR2_RETURN_ONEHOT_EN
    output logic [25:0] out_onehot,
`endif
    output logic        carry_out
);

    logic [4:0] pos_q, pos_d;
    logic       carry_q, carry_d;
    logic       out_valid_q, out_valid_d;
    logic [4:0] out_letter_q, out_letter_d;
    logic       out_error_q, out_error_d;
    logic       accept;
    logic       legal;
    logic [5:0] diff;
    logic [5:0] sum;
    logic [4:0] wired;
    logic [4:0] mapped;

    // Rotor-2 wiring is an involution, so the return path reuses the forward table.
    function automatic logic [4:0] wire_map(input logic [4:0] x);
        logic [4:0] y;
        case (x)
            5'd0:  y = 5'd17;  5'd17: y = 5'd0;
            5'd1:  y = 5'd20;  5'd20: y = 5'd1;
            5'd2:  y = 5'd12;  5'd12: y = 5'd2;
            5'd3:  y = 5'd23;  5'd23: y = 5'd3;
            5'd4:  y = 5'd9;   5'd9:  y = 5'd4;
            5'd5:  y = 5'd10;  5'd10: y = 5'd5;
            5'd6:  y = 5'd15;  5'd15: y = 5'd6;
            5'd7:  y = 5'd18;  5'd18: y = 5'd7;
            5'd8:  y = 5'd25;  5'd25: y = 5'd8;
            5'd11: y = 5'd24;  5'd24: y = 5'd11;
            5'd13: y = 5'd16;  5'd16: y = 5'd13;
            5'd14: y = 5'd21;  5'd21: y = 5'd14;
            5'd19: y = 5'd22;  5'd22: y = 5'd19;
            default: y = x;
        endcase
        return y;
    endfunction

    assign accept   = in_valid && in_ready;
    assign legal    = (in_letter < 5'd26);
    assign in_ready = !out_valid_q || out_ready;

    // Modulo-26 subtract/add done in 6 bits so nothing ever wraps at 32.
    always_comb begin
        diff = {1'b0, in_letter} + 6'd26 - {1'b0, pos_q};
        if (diff >= 6'd26) begin
            diff = diff - 6'd26;
        end
        wired = wire_map(diff[4:0]);
        sum   = {1'b0, wired} + {1'b0, pos_q};
        if (sum >= 6'd26) begin
            sum = sum - 6'd26;
        end
        mapped = sum[4:0];
    end

    always_comb begin
        pos_d   = pos_q;
        carry_d = 1'b0;
        if (set) begin
            pos_d = (set_state < 5'd26) ? set_state : 5'd0;
        end else if (step) begin
            if (pos_q == 5'd25) begin
                pos_d   = 5'd0;
                carry_d = 1'b1;
            end else begin
                pos_d = pos_q + 5'd1;
            end
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_letter_d = out_letter_q;
        out_error_d  = out_error_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_letter_d = legal ? mapped : in_letter;
            out_error_d  = !legal;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pos_q        <= 5'd0;
            carry_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_letter_q <= 5'd0;
            out_error_q  <= 1'b0;
        end else begin
            pos_q        <= pos_d;
            carry_q      <= carry_d;
            out_valid_q  <= out_valid_d;
            out_letter_q <= out_letter_d;
            out_error_q  <= out_error_d;
        end
    end

`ifdef ROTOR2_RETURN_ONEHOT_EN
    logic [25:0] out_onehot_q, out_onehot_d;

    always_comb begin
        out_onehot_d = '0;
        if (out_valid_d && !out_error_d) begin
            out_onehot_d = 26'd1 << out_letter_d;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_onehot_q <= '0;
        end else begin
            out_onehot_q <= out_onehot_d;
        end
    end

    assign out_onehot = out_onehot_q;
`endif

    assign out_valid  = out_valid_q;
    assign out_letter = out_letter_q;
    assign out_error  = out_error_q;
    assign state      = pos_q;
    assign carry_out  = carry_q;

endmodule

// File: tb/tb_rotor2_return.sv
// Self-checking bench for rotor2_return: table-driven vectors plus hand sequences for
// backpressure and asynchronous reset.
module tb_rotor2_return;

    logic        clock;
    logic        resetn;
    logic        set;
    logic [4:0]  set_state;
    logic        step;
    logic        in_valid;
    logic [4:0]  in_letter;
    logic        in_ready;
    logic        out_valid;
    logic [4:0]  out_letter;
    logic        out_error;
    logic        out_ready;
    logic [4:0]  state;
    logic        carry_out;
`ifdef ROTOR2_RETURN_ONEHOT_EN
    logic [25:0] out_onehot;
`endif

    int total_checks;
    int passed_checks;

    rotor2_return dut (
        .clock     (clock),
        .resetn    (resetn),
        .set       (set),
        .set_state (set_state),
        .step      (step),
        .in_valid  (in_valid),
        .in_letter (in_letter),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_letter(out_letter),
        .out_error (out_error),
        .out_ready (out_ready),
        .state     (state),
`ifdef ROTOR2_RETURN_ONEHOT_EN
        .out_onehot(out_onehot),
`endif
        .carry_out (carry_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       set;
        logic [4:0] set_state;
        logic       step;
        logic       in_valid;
        logic [4:0] in_letter;
        logic       exp_valid;
        logic [4:0] exp_letter;
        logic       exp_error;
        logic [4:0] exp_state;
        logic       exp_carry;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input int s, input int ss, input int st, input int iv,
                                input int il, input int ev, input int el, input int ee,
                                input int es, input int ec);
        vec_t v;
        v.set        = 1'(s);
        v.set_state  = 5'(ss);
        v.step       = 1'(st);
        v.in_valid   = 1'(iv);
        v.in_letter  = 5'(il);
        v.exp_valid  = 1'(ev);
        v.exp_letter = 5'(el);
        v.exp_error  = 1'(ee);
        v.exp_state  = 5'(es);
        v.exp_carry  = 1'(ec);
        return v;
    endfunction

    task automatic check_val(input string name, input int actual, input int expected);
        total_checks++;
        if (actual == expected) begin
            passed_checks++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_onehot(input string name, input logic ev, input logic ee,
                                input logic [4:0] el);
`ifdef ROTOR2_RETURN_ONEHOT_EN
        logic [25:0] exp_oh;
        exp_oh = (ev && !ee) ? (26'd1 << el) : 26'd0;
        total_checks++;
        if (out_onehot == exp_oh) begin
            passed_checks++;
        end else begin
            $display("FAIL %s onehot: got %h, expected %h", name, out_onehot, exp_oh);
        end
`else
        if (ev === 1'bx || ee === 1'bx || el === 5'bx) begin
            $display("[TB] unknown onehot expectation for %s", name);
        end
`endif
    endtask

    task automatic drive(input logic s, input logic [4:0] ss, input logic st,
                         input logic iv, input logic [4:0] il, input logic ordy);
        @(negedge clock);
        set       = s;
        set_state = ss;
        step      = st;
        in_valid  = iv;
        in_letter = il;
        out_ready = ordy;
        @(posedge clock);
        #1;
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        resetn    = 1'b0;
        set       = 1'b0;
        set_state = 5'd0;
        step      = 1'b0;
        in_valid  = 1'b0;
        in_letter = 5'd0;
        out_ready = 1'b1;

        vecs[0]  = mk(0,  0, 0, 1,  0, 1, 17, 0,  0, 0);
        vecs[1]  = mk(0,  0, 1, 0,  0, 0,  0, 0,  1, 0);
        vecs[2]  = mk(0,  0, 0, 1,  0, 1,  9, 0,  1, 0);
        vecs[3]  = mk(1, 25, 0, 0,  0, 0,  0, 0, 25, 0);
        vecs[4]  = mk(0,  0, 0, 1,  1, 1, 11, 0, 25, 0);
        vecs[5]  = mk(0,  0, 0, 1, 28, 1, 28, 1, 25, 0);
        vecs[6]  = mk(1, 24, 0, 0,  0, 0,  0, 0, 24, 0);
        vecs[7]  = mk(0,  0, 1, 0,  0, 0,  0, 0, 25, 0);
        vecs[8]  = mk(0,  0, 1, 0,  0, 0,  0, 0,  0, 1);
        vecs[9]  = mk(0,  0, 1, 0,  0, 0,  0, 0,  1, 0);
        vecs[10] = mk(1, 30, 0, 0,  0, 0,  0, 0,  0, 0);
        vecs[11] = mk(0,  0, 1, 1,  0, 1, 17, 0,  1, 0);
        vecs[12] = mk(1,  5, 1, 0,  0, 0,  0, 0,  5, 0);
        vecs[13] = mk(0,  0, 0, 1,  3, 1, 16, 0,  5, 0);
        vecs[14] = mk(1, 25, 0, 0,  0, 0,  0, 0, 25, 0);
        vecs[15] = mk(0,  0, 1, 1,  4, 1,  9, 0,  0, 1);
        vecs[16] = mk(0,  0, 1, 0,  0, 0,  0, 0,  1, 0);
        vecs[17] = mk(1, 25, 0, 1, 31, 1, 31, 1, 25, 0);
        vecs[18] = mk(0,  0, 1, 0,  0, 0,  0, 0,  0, 1);
        vecs[19] = mk(1, 25, 0, 0,  0, 0,  0, 0, 25, 0);
        vecs[20] = mk(0,  0, 1, 0,  0, 0,  0, 0,  0, 1);

        #2;
        check_val("rst in_ready", int'(in_ready), 1);
        check_val("rst out_valid", int'(out_valid), 0);
        check_val("rst out_letter", int'(out_letter), 0);
        check_val("rst out_error", int'(out_error), 0);
        check_val("rst state", int'(state), 0);
        check_val("rst carry", int'(carry_out), 0);
        check_onehot("rst", 1'b0, 1'b0, 5'd0);
        @(negedge clock);
        resetn = 1'b1;

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].set, vecs[i].set_state, vecs[i].step,
                  vecs[i].in_valid, vecs[i].in_letter, 1'b1);
            check_val($sformatf("vec%0d out_valid", i), int'(out_valid), int'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check_val($sformatf("vec%0d out_letter", i), int'(out_letter), int'(vecs[i].exp_letter));
                check_val($sformatf("vec%0d out_error", i), int'(out_error), int'(vecs[i].exp_error));
            end
            check_val($sformatf("vec%0d state", i), int'(state), int'(vecs[i].exp_state));
            check_val($sformatf("vec%0d carry", i), int'(carry_out), int'(vecs[i].exp_carry));
            check_val($sformatf("vec%0d in_ready", i), int'(in_ready), 1);
            check_onehot($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_error,
                         vecs[i].exp_letter);
        end

        // Backpressure: letter 3 at p=0 maps to 23 and must sit while out_ready is low.
        drive(1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0);
        check_val("bp load valid", int'(out_valid), 1);
        check_val("bp load letter", int'(out_letter), 23);
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
            check_val($sformatf("bp hold%0d letter", c), int'(out_letter), 23);
            check_val($sformatf("bp hold%0d valid", c), int'(out_valid), 1);
            check_val($sformatf("bp hold%0d in_ready", c), int'(in_ready), 0);
        end
        @(negedge clock);
        out_ready = 1'b1;
        #1;
        check_val("bp release in_ready", int'(in_ready), 1);
        @(posedge clock);
        #1;
        check_val("bp next letter", int'(out_letter), 17);
        check_val("bp next valid", int'(out_valid), 1);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        check_val("bp drained valid", int'(out_valid), 0);

        // Async reset with a pending beat at p=12.
        drive(1'b1, 5'd12, 1'b0, 1'b1, 5'd0, 1'b0);
        check_val("ar pre valid", int'(out_valid), 1);
        check_val("ar pre letter", int'(out_letter), 17);
        check_val("ar pre state", int'(state), 12);
        @(negedge clock);
        set      = 1'b0;
        in_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check_val("ar out_valid", int'(out_valid), 0);
        check_val("ar state", int'(state), 0);
        check_val("ar carry", int'(carry_out), 0);
        check_val("ar in_ready", int'(in_ready), 1);
        check_onehot("ar", 1'b0, 1'b0, 5'd0);
        @(negedge clock);
        resetn = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1);
        check_val("ar resume valid", int'(out_valid), 1);
        check_val("ar resume letter", int'(out_letter), 17);
        check_onehot("ar resume", 1'b1, 1'b0, 5'd17);
        drive(1'b0, 5'd0, 1'b0, 1'b1, 5'd1, 1'b1);
        check_val("ar b2b letter", int'(out_letter), 20);
        check_val("ar b2b valid", int'(out_valid), 1);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
